// File: rtl/uart_rx_gen.sv
// Parametrised UART receiver: majority-filtered input, runtime baud divisor,
// optional parity, 1/2 stop bits, break detection and a valid/ready output register.
module uart_rx_gen #(
    parameter int C_DATA_BITS = 8,
    parameter int C_PARITY    = 0,
    parameter int C_STOP_BITS = 1,
    parameter int C_DIV_W     = 12
) (
    input  logic                   CLK_100M,
    input  logic                   IO_RESET,
    input  logic [C_DIV_W-1:0]     UART_BIT_CNT,
    input  logic                   UART_RXD,
    output logic [C_DATA_BITS-1:0] UART_RX_DATA,
    output logic                   UART_RX_VALID,
    input  logic                   UART_RX_READY,
    output logic                   UART_RX_PERR,
    output logic                   UART_RX_FERR,
    output logic                   UART_RX_OVERRUN,
    output logic                   UART_RX_BREAK
);

    localparam int BIT_W = $clog2(C_DATA_BITS + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

    logic [1:0]             sync_q;
    logic [2:0]             filt_q;
    logic                   rxd;
    state_t                 state_q, state_d;
    logic [C_DIV_W-1:0]     cnt_q, cnt_d, div_q, div_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [C_DATA_BITS-1:0] shift_q, shift_d;
    logic                   par_q, par_d, ferr_q, ferr_d;
    logic                   stop_q, stop_d, stop_hi_q, stop_hi_d;
    logic                   mid, bit_end, done, brk, frame_ferr, frame_perr;

    logic [C_DATA_BITS-1:0] data_q;
    logic                   valid_q, perr_q, ferr_out_q, ovr_q, brk_q;

    always_ff @(posedge CLK_100M or posedge IO_RESET) begin
        if (IO_RESET) begin
            sync_q <= '1;
            filt_q <= '1;
        end else begin
            sync_q <= {sync_q[0], UART_RXD};
            filt_q <= {filt_q[1:0], sync_q[1]};
        end
    end

    assign rxd     = (filt_q[0] & filt_q[1]) | (filt_q[0] & filt_q[2]) | (filt_q[1] & filt_q[2]);
    assign mid     = (cnt_q == (div_q >> 1));
    assign bit_end = (cnt_q == div_q);

    // Even parity flags an error when data^parity is 1; odd when it is 0.
    assign frame_perr = (C_PARITY != 0) && ((^shift_q ^ par_q) != (C_PARITY == 2));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        ferr_d     = ferr_q;
        stop_d     = stop_q;
        stop_hi_d  = stop_hi_q;
        done       = 1'b0;
        brk        = 1'b0;
        frame_ferr = 1'b0;
        if (state_q != IDLE && state_q != BRK_WAIT)
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (!rxd) begin
                    state_d   = START;
                    cnt_d     = '0;
                    div_d     = UART_BIT_CNT;
                    bit_d     = '0;
                    par_d     = 1'b0;
                    ferr_d    = 1'b0;
                    stop_d    = 1'b0;
                    stop_hi_d = 1'b0;
                end
            end
            START: begin
                if (mid && rxd)
                    state_d = IDLE;
                else if (bit_end)
                    state_d = DATA;
            end
            DATA: begin
                if (mid)
                    shift_d = {rxd, shift_q[C_DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bit_q == BIT_W'(C_DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (C_PARITY != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (mid)
                    par_d = rxd;
                if (bit_end)
                    state_d = STOP;
            end
            STOP: begin
                // Complete at mid of the last stop bit so the next start edge is caught.
                if (mid) begin
                    if (stop_q == 1'(C_STOP_BITS - 1)) begin
                        done       = 1'b1;
                        frame_ferr = ferr_q | ~rxd;
                        brk        = (shift_q == '0) && ((C_PARITY == 0) || !par_q) && !stop_hi_q && !rxd;
                        state_d    = brk ? BRK_WAIT : IDLE;
                    end else begin
                        ferr_d    = ferr_q | ~rxd;
                        stop_hi_d = stop_hi_q | rxd;
                    end
                end else if (bit_end) begin
                    stop_d = 1'b1;
                end
            end
            BRK_WAIT: begin
                if (rxd)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_100M or posedge IO_RESET) begin
        if (IO_RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            ferr_q    <= 1'b0;
            stop_q    <= 1'b0;
            stop_hi_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            ferr_q    <= ferr_d;
            stop_q    <= stop_d;
            stop_hi_q <= stop_hi_d;
        end
    end

    always_ff @(posedge CLK_100M or posedge IO_RESET) begin
        if (IO_RESET) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            brk_q <= 1'b0;
            if (done && brk) begin
                brk_q <= 1'b1;
            end else if (done && (!valid_q || UART_RX_READY)) begin
                data_q     <= shift_q;
                perr_q     <= frame_perr;
                ferr_out_q <= frame_ferr;
                valid_q    <= 1'b1;
            end else if (done) begin
                ovr_q <= 1'b1;
            end else if (valid_q && UART_RX_READY) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign UART_RX_DATA    = data_q;
    assign UART_RX_VALID   = valid_q;
    assign UART_RX_PERR    = perr_q;
    assign UART_RX_FERR    = ferr_out_q;
    assign UART_RX_OVERRUN = ovr_q;
    assign UART_RX_BREAK   = brk_q;

endmodule

// File: tb/tb_uart_rx_gen.sv
// Directed bench for uart_rx_gen: 8N1, even- and odd-parity instances share one RXD line.
module tb_uart_rx_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] bit_cnt;
    logic        rxd;
    logic        ready;

    logic [7:0]  n_data, e_data, o_data;
    logic        n_valid, n_perr, n_ferr, n_ovr, n_brk;
    logic        e_valid, e_perr, e_ferr, e_ovr, e_brk;
    logic        o_valid, o_perr, o_ferr, o_ovr, o_brk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int stop_cyc = 0;
    int v_cnt = 0, vhi_cnt = 0, v_cyc = 0, ovr_cnt = 0, brk_cnt = 0;
    int e_cnt = 0, o_cnt = 0;
    logic n_prev = 1'b0, e_prev = 1'b0, o_prev = 1'b0;

    always #5 clk = ~clk;

    uart_rx_gen #(.C_DATA_BITS(8), .C_PARITY(0), .C_STOP_BITS(1), .C_DIV_W(12)) dut (
        .CLK_100M(clk), .IO_RESET(rst), .UART_BIT_CNT(bit_cnt), .UART_RXD(rxd),
        .UART_RX_DATA(n_data), .UART_RX_VALID(n_valid), .UART_RX_READY(ready),
        .UART_RX_PERR(n_perr), .UART_RX_FERR(n_ferr), .UART_RX_OVERRUN(n_ovr), .UART_RX_BREAK(n_brk));

    uart_rx_gen #(.C_DATA_BITS(8), .C_PARITY(1), .C_STOP_BITS(1), .C_DIV_W(12)) dut_e (
        .CLK_100M(clk), .IO_RESET(rst), .UART_BIT_CNT(bit_cnt), .UART_RXD(rxd),
        .UART_RX_DATA(e_data), .UART_RX_VALID(e_valid), .UART_RX_READY(ready),
        .UART_RX_PERR(e_perr), .UART_RX_FERR(e_ferr), .UART_RX_OVERRUN(e_ovr), .UART_RX_BREAK(e_brk));

    uart_rx_gen #(.C_DATA_BITS(8), .C_PARITY(2), .C_STOP_BITS(1), .C_DIV_W(12)) dut_o (
        .CLK_100M(clk), .IO_RESET(rst), .UART_BIT_CNT(bit_cnt), .UART_RXD(rxd),
        .UART_RX_DATA(o_data), .UART_RX_VALID(o_valid), .UART_RX_READY(ready),
        .UART_RX_PERR(o_perr), .UART_RX_FERR(o_ferr), .UART_RX_OVERRUN(o_ovr), .UART_RX_BREAK(o_brk));

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: counts rising VALID edges, VALID-high cycles and pulses.
    always @(negedge clk) begin
        if (n_valid && !n_prev) begin
            v_cnt <= v_cnt + 1;
            v_cyc <= cyc;
        end
        if (n_valid) vhi_cnt <= vhi_cnt + 1;
        if (n_ovr)   ovr_cnt <= ovr_cnt + 1;
        if (n_brk)   brk_cnt <= brk_cnt + 1;
        if (e_valid && !e_prev) e_cnt <= e_cnt + 1;
        if (o_valid && !o_prev) o_cnt <= o_cnt + 1;
        n_prev <= n_valid;
        e_prev <= e_valid;
        o_prev <= o_valid;
    end

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                              input logic sbit, input int div);
        rxd = 1'b0;
        repeat (div + 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (div + 1) @(negedge clk);
        end
        if (has_par) begin
            rxd = pbit;
            repeat (div + 1) @(negedge clk);
        end
        stop_cyc = cyc;
        rxd = sbit;
        repeat (div + 1) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; rxd = 1'b1; ready = 1'b1; bit_cnt = 12'd15;
        repeat (3) @(negedge clk);
        checks++; if (n_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", n_data); end
        checks++; if (n_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", n_valid); end
        checks++; if (n_perr !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", n_perr); end
        checks++; if (n_ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", n_ferr); end
        checks++; if (n_ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr got=%b exp=0", n_ovr); end
        checks++; if (n_brk !== 1'b0) begin errors++; $display("FAIL reset_brk got=%b exp=0", n_brk); end
        rst = 1'b0;
        idle(20);
        checks++; if (n_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got=%b exp=0", n_valid); end
    endtask

    task automatic test_basic;
        int v0, h0, lat;
        v0 = v_cnt; h0 = vhi_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 15);
        idle(40);
        lat = v_cyc - stop_cyc;
        checks++; if (v_cnt - v0 !== 1) begin errors++; $display("FAIL basic_vcount got=%0d exp=1", v_cnt - v0); end
        checks++; if (vhi_cnt - h0 !== 1) begin errors++; $display("FAIL basic_vwidth got=%0d exp=1", vhi_cnt - h0); end
        checks++; if (n_data !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h exp=a5", n_data); end
        checks++; if (n_perr !== 1'b0) begin errors++; $display("FAIL basic_perr got=%b exp=0", n_perr); end
        checks++; if (n_ferr !== 1'b0) begin errors++; $display("FAIL basic_ferr got=%b exp=0", n_ferr); end
        checks++; if (lat < 12 || lat > 14) begin errors++; $display("FAIL basic_latency got=%0d exp=12..14", lat); end
    endtask

    task automatic test_parity;
        int e0, o0;
        bit_cnt = 12'd15;
        e0 = e_cnt; o0 = o_cnt;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 15);
        idle(40);
        checks++; if (e_cnt - e0 !== 1) begin errors++; $display("FAIL par_e_vcount got=%0d exp=1", e_cnt - e0); end
        checks++; if (e_data !== 8'h03) begin errors++; $display("FAIL par_e_data got=%h exp=03", e_data); end
        checks++; if (e_perr !== 1'b1) begin errors++; $display("FAIL par_e_p1 got=%b exp=1", e_perr); end
        checks++; if (o_perr !== 1'b0) begin errors++; $display("FAIL par_o_p1 got=%b exp=0", o_perr); end
        checks++; if (o_ferr !== 1'b0) begin errors++; $display("FAIL par_o_ferr got=%b exp=0", o_ferr); end
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 15);
        idle(40);
        checks++; if (o_cnt - o0 !== 2) begin errors++; $display("FAIL par_o_vcount got=%0d exp=2", o_cnt - o0); end
        checks++; if (e_perr !== 1'b0) begin errors++; $display("FAIL par_e_p0 got=%b exp=0", e_perr); end
        checks++; if (o_perr !== 1'b1) begin errors++; $display("FAIL par_o_p0 got=%b exp=1", o_perr); end
        checks++; if (o_data !== 8'h03) begin errors++; $display("FAIL par_o_data got=%h exp=03", o_data); end
    endtask

    task automatic test_glitch;
        int v0, b0;
        v0 = v_cnt; b0 = brk_cnt;
        rxd = 1'b0; @(negedge clk);
        idle(40);
        rxd = 1'b0; repeat (3) @(negedge clk);
        idle(60);
        checks++; if (v_cnt - v0 !== 0) begin errors++; $display("FAIL glitch_vcount got=%0d exp=0", v_cnt - v0); end
        checks++; if (brk_cnt - b0 !== 0) begin errors++; $display("FAIL glitch_brk got=%0d exp=0", brk_cnt - b0); end
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, 15);
        idle(40);
        checks++; if (n_data !== 8'h96) begin errors++; $display("FAIL glitch_after_data got=%h exp=96", n_data); end
    endtask

    task automatic test_overrun;
        int r0;
        ready = 1'b0;
        r0 = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 15);
        idle(40);
        checks++; if (n_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid1 got=%b exp=1", n_valid); end
        checks++; if (ovr_cnt - r0 !== 0) begin errors++; $display("FAIL ovr_first got=%0d exp=0", ovr_cnt - r0); end
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 15);
        idle(40);
        checks++; if (ovr_cnt - r0 !== 1) begin errors++; $display("FAIL ovr_second got=%0d exp=1", ovr_cnt - r0); end
        checks++; if (n_data !== 8'h11) begin errors++; $display("FAIL ovr_data got=%h exp=11", n_data); end
        checks++; if (n_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid2 got=%b exp=1", n_valid); end
        ready = 1'b1; @(negedge clk);
        ready = 1'b0; @(negedge clk);
        checks++; if (n_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got=%b exp=0", n_valid); end
        checks++; if (n_data !== 8'h11) begin errors++; $display("FAIL ovr_hold got=%h exp=11", n_data); end
        ready = 1'b1;
        idle(10);
    endtask

    task automatic test_break;
        int v0, b0, r0;
        v0 = v_cnt; b0 = brk_cnt; r0 = ovr_cnt;
        rxd = 1'b0;
        repeat (20 * 16) @(negedge clk);
        idle(40);
        checks++; if (brk_cnt - b0 !== 1) begin errors++; $display("FAIL brk_count got=%0d exp=1", brk_cnt - b0); end
        checks++; if (v_cnt - v0 !== 0) begin errors++; $display("FAIL brk_vcount got=%0d exp=0", v_cnt - v0); end
        checks++; if (ovr_cnt - r0 !== 0) begin errors++; $display("FAIL brk_ovr got=%0d exp=0", ovr_cnt - r0); end
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 15);
        idle(40);
        checks++; if (v_cnt - v0 !== 1) begin errors++; $display("FAIL brk_after_vcount got=%0d exp=1", v_cnt - v0); end
        checks++; if (n_data !== 8'h5A) begin errors++; $display("FAIL brk_after_data got=%h exp=5a", n_data); end
    endtask

    task automatic test_div_change;
        bit_cnt = 12'd15;
        fork
            send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 15);
            begin
                repeat (40) @(negedge clk);
                bit_cnt = 12'd7;
            end
        join
        idle(40);
        checks++; if (n_data !== 8'hC3) begin errors++; $display("FAIL divchg_data got=%h exp=c3", n_data); end
        checks++; if (n_ferr !== 1'b0) begin errors++; $display("FAIL divchg_ferr got=%b exp=0", n_ferr); end
        bit_cnt = 12'd15;
        idle(10);
    endtask

    task automatic test_framing;
        bit_cnt = 12'd15;
        send_frame(8'h80, 1'b0, 1'b0, 1'b0, 15);
        idle(40);
        checks++; if (n_data !== 8'h80) begin errors++; $display("FAIL ferr_data got=%h exp=80", n_data); end
        checks++; if (n_ferr !== 1'b1) begin errors++; $display("FAIL ferr_flag got=%b exp=1", n_ferr); end
        bit_cnt = 12'd7;
        idle(10);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 7);
        idle(40);
        checks++; if (n_data !== 8'h3C) begin errors++; $display("FAIL div7_data got=%h exp=3c", n_data); end
        checks++; if (n_ferr !== 1'b0) begin errors++; $display("FAIL div7_ferr got=%b exp=0", n_ferr); end
    endtask

    task automatic test_reset_mid;
        int v0;
        bit_cnt = 12'd15;
        v0 = v_cnt;
        rxd = 1'b0; repeat (16) @(negedge clk);
        rxd = 1'b1; repeat (16) @(negedge clk);
        rxd = 1'b0; repeat (24) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (n_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got=%h exp=00", n_data); end
        checks++; if (n_ferr !== 1'b0) begin errors++; $display("FAIL rstmid_ferr got=%b exp=0", n_ferr); end
        checks++; if (n_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", n_valid); end
        @(negedge clk);
        rst = 1'b0;
        idle(300);
        checks++; if (v_cnt - v0 !== 0) begin errors++; $display("FAIL rstmid_vcount got=%0d exp=0", v_cnt - v0); end
        checks++; if (n_brk !== 1'b0) begin errors++; $display("FAIL rstmid_brk got=%b exp=0", n_brk); end
    endtask

    initial begin
        rst = 1'b1; rxd = 1'b1; ready = 1'b1; bit_cnt = 12'd15;
        @(negedge clk);
        test_reset;
        test_basic;
        test_parity;
        test_glitch;
        test_overrun;
        test_break;
        test_div_change;
        test_framing;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
